// File: rtl/divider_if.sv
// M-extension funct3 encodings and the EX <-> divider request bundle.
// The EX stage drives operands and holds is_div until div_done.
package m_extension;
    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_funct3;
endpackage

interface divider_if;
    import m_extension::*;

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    m_funct3     funct3;
    logic        is_div;
    logic        div_done;
    logic [31:0] div_out;

    modport master (
        output rs1_data, rs2_data, funct3, is_div,
        input  div_done, div_out
    );

    modport slave (
        input  rs1_data, rs2_data, funct3, is_div,
        output div_done, div_out
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for div/divu/rem/remu.
// Corner cases (x/0, signed overflow) bypass the iteration loop.
module divider
    import m_extension::*;
(
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [32:0] r;
    logic [31:0] q, d, res;
    logic        sign_q, sign_r, rem_op;

    logic        op_signed, op_rem, div0, ovf;
    logic [31:0] mag1, mag2, spec_res;
    logic [33:0] t;

    always_comb begin
        op_signed = (bus.funct3 == M_DIV) || (bus.funct3 == M_REM);
        op_rem    = (bus.funct3 == M_REM) || (bus.funct3 == M_REMU);
        div0      = (bus.rs2_data == 32'd0);
        ovf       = op_signed && (bus.rs1_data == 32'h8000_0000)
                    && (bus.rs2_data == 32'hFFFF_FFFF);
        mag1      = (op_signed && bus.rs1_data[31]) ? -bus.rs1_data
                                                    : bus.rs1_data;
        mag2      = (op_signed && bus.rs2_data[31]) ? -bus.rs2_data
                                                    : bus.rs2_data;
        spec_res  = 32'd0;
        unique case (1'b1)
            div0:    spec_res = op_rem ? bus.rs1_data : 32'hFFFF_FFFF;
            ovf:     spec_res = op_rem ? 32'd0 : 32'h8000_0000;
            default: spec_res = 32'd0;
        endcase
    end

    // R stays below D, so r[32] is always zero and acts as the sign guard.
    assign t = {r, q[31]} - {2'b00, d};

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.is_div)
                    state_nx = (div0 || ovf) ? DONE : ITER;
            end
            ITER: begin
                if (!bus.is_div)
                    state_nx = IDLE;
                else if (cnt == 5'd31)
                    state_nx = FIX;
            end
            FIX:  state_nx = bus.is_div ? DONE : IDLE;
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            r      <= '0;
            q      <= '0;
            d      <= '0;
            res    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            rem_op <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (bus.is_div) begin
                        sign_q <= op_signed
                                  & (bus.rs1_data[31] ^ bus.rs2_data[31]);
                        sign_r <= op_signed & bus.rs1_data[31];
                        rem_op <= op_rem;
                        r      <= '0;
                        q      <= mag1;
                        d      <= mag2;
                        cnt    <= '0;
                        if (div0 || ovf)
                            res <= spec_res;
                    end
                end
                ITER: begin
                    if (!t[33]) begin
                        r <= t[32:0];
                        q <= {q[30:0], 1'b1};
                    end else begin
                        r <= {r[31:0], q[31]};
                        q <= {q[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    if (bus.is_div) begin
                        if (rem_op)
                            res <= sign_r ? -r[31:0] : r[31:0];
                        else
                            res <= sign_q ? -q : q;
                    end
                end
                DONE: ;
            endcase
        end
    end

    assign bus.div_done = (state == DONE);
    assign bus.div_out  = res;
endmodule
